// File: rtl/risc_pkg.sv
// Shared definitions for the program loader:
// FSM state encoding and memory geometry defaults.
package risc_pkg;

   localparam int RISC_ADDR_W = 8;
   localparam int RISC_DEPTH  = 256;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_CHK  = 3'd2,
      ST_RUN  = 3'd3,
      ST_ERR  = 3'd4
   } ldr_state_t;

endpackage

// File: rtl/prog_loader_cksum.sv
// Modulo-2^16 running sum of the program words.
// Clear wins over enable.
module prog_loader_cksum (
   input  logic        clk,
   input  logic        i_clr,
   input  logic        i_en,
   input  logic [15:0] i_data,
   output logic [15:0] o_sum
);

   logic [15:0] r_sum;

   // accumulate accepted program words, wrapping at 16 bits
   always_ff @(posedge clk) begin
      if (i_clr) begin
         r_sum <= '0;
      end else if (i_en) begin
         r_sum <= r_sum + i_data;
      end
   end

   assign o_sum = r_sum;

endmodule

// File: rtl/prog_loader.sv
// Streams a length-prefixed, checksummed image into
// instruction memory and releases the core on success.
module prog_loader
   import risc_pkg::*;
#(
   parameter int ADDR_W = RISC_ADDR_W,
   parameter int DEPTH  = RISC_DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              s_valid,
   input  logic [15:0]       s_data,
   output logic              s_ready,
   input  logic              restart,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [15:0]       imem_wdata,
   output logic              core_reset,
   output logic              load_done,
   output logic              load_err
);

   ldr_state_t r_state;
   ldr_state_t w_nxt;

   logic [ADDR_W:0]   r_len;
   logic [ADDR_W-1:0] r_idx;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [15:0]       r_wdata;

   logic        w_xfer;
   logic        w_ld_len;
   logic        w_idx_clr;
   logic        w_idx_inc;
   logic        w_sum_clr;
   logic        w_sum_en;
   logic        w_wr;
   logic        w_last;
   logic        w_bad_len;
   logic [15:0] w_sum;

   assign s_ready = reset & ((r_state == ST_IDLE) |
                             (r_state == ST_LOAD) |
                             (r_state == ST_CHK));
   assign w_xfer  = s_valid & s_ready;

   assign w_last    = ({1'b0, r_idx} ==
                       (r_len - (ADDR_W+1)'(1)));
   assign w_bad_len = (s_data == 16'd0) |
                      ({1'b0, s_data} > 17'(DEPTH));

   // state register
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nxt;
      end
   end

   // next state and datapath controls
   always_comb begin
      w_nxt     = r_state;
      w_ld_len  = 1'b0;
      w_idx_clr = 1'b0;
      w_idx_inc = 1'b0;
      w_sum_clr = 1'b0;
      w_sum_en  = 1'b0;
      w_wr      = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_xfer) begin
               if (w_bad_len) begin
                  w_nxt = ST_ERR;
               end else begin
                  w_nxt     = ST_LOAD;
                  w_ld_len  = 1'b1;
                  w_idx_clr = 1'b1;
                  w_sum_clr = 1'b1;
               end
            end
         end
         ST_LOAD: begin
            if (w_xfer) begin
               w_wr      = 1'b1;
               w_sum_en  = 1'b1;
               w_idx_inc = 1'b1;
               if (w_last) begin
                  w_nxt = ST_CHK;
               end
            end
         end
         ST_CHK: begin
            if (w_xfer) begin
               w_nxt = (s_data == w_sum) ? ST_RUN : ST_ERR;
            end
         end
         ST_RUN, ST_ERR: begin
            if (restart) begin
               w_nxt     = ST_IDLE;
               w_idx_clr = 1'b1;
               w_sum_clr = 1'b1;
            end
         end
         default: begin
            w_nxt = ST_IDLE;
         end
      endcase
   end

   // length latch, word index and registered imem write port
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_len   <= '0;
         r_idx   <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else begin
         r_we <= w_wr;
         if (w_wr) begin
            r_addr  <= r_idx;
            r_wdata <= s_data;
         end
         if (w_ld_len) begin
            r_len <= s_data[ADDR_W:0];
         end
         if (w_idx_clr) begin
            r_idx <= '0;
         end else if (w_idx_inc) begin
            r_idx <= r_idx + 1'b1;
         end
      end
   end

   prog_loader_cksum u_cksum (
      .clk    (clk),
      .i_clr  (w_sum_clr | ~reset),
      .i_en   (w_sum_en),
      .i_data (s_data),
      .o_sum  (w_sum)
   );

   assign imem_we    = r_we;
   assign imem_addr  = r_addr;
   assign imem_wdata = r_wdata;
   assign core_reset = (r_state != ST_RUN);
   assign load_done  = (r_state == ST_RUN);
   assign load_err   = (r_state == ST_ERR);

endmodule
